regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the pipelined CPU.
- Provides NREAD combinational read ports and two write ports:
  - port 0: main pipeline writeback.
  - port 1: late writeback from the multi-cycle unit.
- Same-cycle write-through bypass on every read port.
- Per-register pending scoreboard. The decode stage uses it to stall on operands whose long-latency producer has not yet written back.

---
 rtl/regfile_sb.sv | 111 +++++++++++
 tb/tb_regfile_sb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with NREAD bypassed read ports, two prioritised write ports,
// and a per-register pending scoreboard for long-latency producers.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_pending,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pending_cnt,
  output logic                     wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   cnt_next;
  logic              conflict_reg;

  logic same_addr;
  logic wr0_eff;
  logic wr1_eff;

  assign same_addr = wr0_en && wr1_en && (wr0_addr == wr1_addr);
  assign wr0_eff   = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  // wr1 loses to wr0 on an address collision.
  assign wr1_eff   = wr1_en && !same_addr && !((ZERO_REG != 0) && (wr1_addr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (wr1_eff) mem_reg[wr1_addr] <= wr1_data;
      if (wr0_eff) mem_reg[wr0_addr] <= wr0_data;
    end
  end

  // Mark outranks a same-cycle write: the marking instruction is younger.
  always_comb begin
    pend_next = pend_reg;
    cnt_next  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (flush) begin
        pend_next[r] = 1'b0;
      end else if (mark_en && (mark_addr == ADDR_W'(r))) begin
        pend_next[r] = 1'b1;
      end else if ((wr0_en && (wr0_addr == ADDR_W'(r))) ||
                   (wr1_en && (wr1_addr == ADDR_W'(r)))) begin
        pend_next[r] = 1'b0;
      end
      if ((ZERO_REG != 0) && (r == 0)) pend_next[r] = 1'b0;
      cnt_next = cnt_next + (ADDR_W+1)'(pend_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg     <= '0;
      cnt_reg      <= '0;
      conflict_reg <= 1'b0;
    end else begin
      pend_reg     <= pend_next;
      cnt_reg      <= cnt_next;
      conflict_reg <= same_addr;
    end
  end

  assign pending_cnt = cnt_reg;
  assign wr_conflict = conflict_reg;

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_sel;
      logic              hit0;
      logic              hit1;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign hit0 = wr0_en && (wr0_addr == addr);
      assign hit1 = wr1_en && (wr1_addr == addr);

      always_comb begin
        if ((ZERO_REG != 0) && (addr == '0)) data_sel = '0;
        else if (hit0)                       data_sel = wr0_data;
        else if (hit1)                       data_sel = wr1_data;
        else                                 data_sel = mem_reg[addr];
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_sel;
      // A result landing this cycle is bypassed, so it no longer stalls.
      assign rd_pending[gi] = pend_reg[addr] && !(hit0 || hit1);
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NREAD=4): bypass, write priority, zero
// register, scoreboard mark/clear/flush, and reset override.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_pending;
  logic                    wr0_en, wr1_en, mark_en, flush;
  logic [ADDR_W-1:0]       wr0_addr, wr1_addr, mark_addr;
  logic [DATA_W-1:0]       wr0_data, wr1_data;
  logic [ADDR_W:0]         pending_cnt;
  logic                    wr_conflict;

  int checks = 0;
  int failures = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .flush(flush),
    .pending_cnt(pending_cnt), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
    rd_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; mark_en = 0; flush = 0; reset = 0;
  endtask

  // Advance through a rising edge and settle just after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; idle(); reset = 1;
    rd_addr = '0; wr0_addr = '0; wr1_addr = '0; mark_addr = '0;
    wr0_data = '0; wr1_data = '0;
    tick(); tick();
    reset = 0;

    // Reset state
    set_rd(0, 5); set_rd(1, 31); #1;
    check("rst_rd0", rd(0), 0);
    check("rst_rd1", rd(1), 0);
    check("rst_pend", {28'd0, rd_pending}, 0);
    check("rst_cnt", {26'd0, pending_cnt}, 0);
    check("rst_conflict", {31'd0, wr_conflict}, 0);

    // wr0 bypass then stored value
    wr0_en = 1; wr0_addr = 8; wr0_data = 32'h1234ABCD; set_rd(0, 8); #1;
    check("byp0_rd", rd(0), 32'h1234ABCD);
    tick(); idle(); #1;
    check("stored8", rd(0), 32'h1234ABCD);

    // wr0/wr1 collision on $9: wr0 wins, conflict pulses once
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h22; set_rd(0, 9); #1;
    check("coll_byp", rd(0), 32'h11);
    tick();
    check("conflict_1", {31'd0, wr_conflict}, 1);
    idle(); #1;
    check("coll_stored", rd(0), 32'h11);
    tick();
    check("conflict_0", {31'd0, wr_conflict}, 0);

    // Register 0 ignores writes and bypass
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; set_rd(1, 0); #1;
    check("zero_byp", rd(1), 0);
    tick(); idle(); #1;
    check("zero_stored", rd(1), 0);

    // Mark $10, then clear via wr1 with bypass
    mark_en = 1; mark_addr = 10; set_rd(0, 10); #1;
    check("mark_same_cycle_pend", {31'd0, rd_pending[0]}, 0);
    tick(); idle(); #1;
    check("mark_cnt", {26'd0, pending_cnt}, 1);
    check("mark_pend", {31'd0, rd_pending[0]}, 1);
    wr1_en = 1; wr1_addr = 10; wr1_data = 32'h55; #1;
    check("wr1_clear_pend", {31'd0, rd_pending[0]}, 0);
    check("wr1_byp", rd(0), 32'h55);
    tick(); idle(); #1;
    check("wr1_cnt", {26'd0, pending_cnt}, 0);

    // Mark beats same-cycle write
    mark_en = 1; mark_addr = 12; wr0_en = 1; wr0_addr = 12; wr0_data = 32'h77; set_rd(0, 12);
    tick(); idle(); #1;
    check("markwin_cnt", {26'd0, pending_cnt}, 1);
    check("markwin_pend", {31'd0, rd_pending[0]}, 1);
    check("markwin_data", rd(0), 32'h77);
    mark_en = 1; mark_addr = 13;
    tick();
    check("mark13_cnt", {26'd0, pending_cnt}, 2);
    mark_en = 1; mark_addr = 14; flush = 1;
    tick(); idle(); #1;
    check("flush_cnt", {26'd0, pending_cnt}, 0);
    set_rd(0, 13); set_rd(1, 14); set_rd(2, 12); #1;
    check("flush_pend", {28'd0, rd_pending}, 0);

    // Mark on $0 is ignored
    mark_en = 1; mark_addr = 0;
    tick(); idle(); #1;
    check("mark0_cnt", {26'd0, pending_cnt}, 0);

    // Reset overrides write and mark in the same cycle
    mark_en = 1; mark_addr = 3;
    tick(); idle(); #1;
    check("pre_rst_cnt", {26'd0, pending_cnt}, 1);
    reset = 1; wr0_en = 1; wr0_addr = 4; wr0_data = 32'h99; mark_en = 1; mark_addr = 5;
    tick(); idle(); #1;
    check("rst2_cnt", {26'd0, pending_cnt}, 0);
    set_rd(0, 8); set_rd(1, 9); set_rd(2, 4); set_rd(3, 3); #1;
    check("rst2_rd8", rd(0), 0);
    check("rst2_rd9", rd(1), 0);
    check("rst2_rd4", rd(2), 0);
    check("rst2_pend", {28'd0, rd_pending}, 0);

    // Four read ports on four distinct registers
    for (int i = 1; i <= 4; i++) begin
      wr0_en = 1; wr0_addr = ADDR_W'(i); wr0_data = 32'hA0 + i;
      tick();
    end
    idle();
    set_rd(0, 4); set_rd(1, 3); set_rd(2, 2); set_rd(3, 1); #1;
    check("p0_r4", rd(0), 32'hA4);
    check("p1_r3", rd(1), 32'hA3);
    check("p2_r2", rd(2), 32'hA2);
    check("p3_r1", rd(3), 32'hA1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
